fifo_ctrl: RTL

//  Upstream control stage for mem_mod: turns the memory into a synchronous FIFO.
//  - Accepts a valid/ready write stream and drives mem_mod write port.
//  - Drives mem_mod read port and presents head data as a valid/ready read stream.
//  - Tracks occupancy, almost-full and a clearable high-water mark.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ctrl_if.sv | 40 ++++
 rtl/fifo_ptr.sv | 48 ++++
 rtl/mem_mod.sv | 34 +++
 rtl/fifo_ctrl.sv | 114 +++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: pointer widths, op encoding, depth check.
// A pointer is laid out as {phase, idx}: the phase bit is the MSB above an addr_w(DEPTH)-bit index.
package fifo_pkg;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return depth >= 2;
  endfunction

  // Encoded as {pop, push} so the handshake bits cast straight into it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Write stream, read stream, mem_mod port and status bundle of the FIFO controller.
// master = controller side, slave = producer/consumer/memory side.
interface fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  import fifo_pkg::*;

  localparam int unsigned ADDRSIZE = addr_w(DEPTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  mem_wr_en;
  logic [ADDRSIZE-1:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_rd_en;
  logic [ADDRSIZE-1:0]   mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [ADDRSIZE:0]     count;
  logic                  almost_full;
  logic [ADDRSIZE:0]     hwm;
  logic                  clr_hwm;

  modport master (
    input  in_valid, in_data, out_ready, mem_rd_data, clr_hwm,
    output in_ready, out_valid, out_data, mem_wr_en, mem_wr_addr, mem_wr_data,
           mem_rd_en, mem_rd_addr, count, almost_full, hwm
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rd_data, clr_hwm,
    input  in_ready, out_valid, out_data, mem_wr_en, mem_wr_addr, mem_wr_data,
           mem_rd_en, mem_rd_addr, count, almost_full, hwm
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap counter for one FIFO pointer: idx runs 0..DEPTH-1, phase toggles on each wrap.
// Advances one step per cycle with inc; async reset to {0, 0}.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = addr_w(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [AW:0] ptr
);

  typedef struct packed {
    logic          phase;
    logic [AW-1:0] idx;
  } ptr_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  ptr_t ptr_q;
  ptr_t ptr_d;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the array.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q.idx == LAST_IDX) begin
        ptr_d.idx   = '0;
        ptr_d.phase = ~ptr_q.phase;
      end else begin
        ptr_d.idx = ptr_q.idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_mod.sv
// Simple dual-port storage: synchronous write, combinational read gated by rd_en.
// Contents are not reset; out-of-range addresses are ignored on write and read as zero.
module mem_mod
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_ADDR   = 16,
  localparam int unsigned AW         = addr_w(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [MAX_ADDR];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < MAX_ADDR)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en && (32'(rd_addr) < MAX_ADDR)) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO control over mem_mod: first word visible the cycle after its push edge, no bypass.
// in_ready = !full, out_valid = !empty; a full FIFO pops first and accepts the write a cycle later.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_LVL  = DEPTH - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.master bus
);

  localparam int unsigned ADDRSIZE = addr_w(DEPTH);
  localparam int unsigned CW       = ADDRSIZE + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_ctrl: DEPTH must be at least 2");
  end

  if ($bits(bus.in_data) != DATA_WIDTH) begin : g_bad_width
    $error("fifo_ctrl: interface DATA_WIDTH does not match");
  end

  typedef struct packed {
    logic                phase;
    logic [ADDRSIZE-1:0] idx;
  } ptr_t;

  ptr_t     wr_ptr;
  ptr_t     rd_ptr;
  logic     empty;
  logic     full;
  logic     push;
  logic     pop;
  fifo_op_e op;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          almost_full_q;
  logic          almost_full_d;
  logic [CW-1:0] hwm_q;
  logic [CW-1:0] hwm_d;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Equal indices are disambiguated by the phase bits: same lap = empty, one lap apart = full.
  assign empty = (wr_ptr.idx == rd_ptr.idx) && (wr_ptr.phase == rd_ptr.phase);
  assign full  = (wr_ptr.idx == rd_ptr.idx) && (wr_ptr.phase != rd_ptr.phase);

  assign push = bus.in_valid & ~full;
  assign pop  = bus.out_ready & ~empty;
  assign op   = fifo_op_e'({pop, push});

  assign bus.in_ready    = ~full;
  assign bus.out_valid   = ~empty;
  assign bus.out_data    = bus.mem_rd_data;
  assign bus.mem_wr_en   = push;
  assign bus.mem_wr_addr = wr_ptr.idx;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_rd_en   = ~empty;
  assign bus.mem_rd_addr = rd_ptr.idx;

  always_comb begin
    count_d = count_q;
    unique case (op)
      OP_PUSH: count_d = count_q + 1'b1;
      OP_POP:  count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    almost_full_d = (count_d >= AFULL_C);

    // A clear restarts tracking from the occupancy that this edge produces.
    if (bus.clr_hwm) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      almost_full_q <= 1'b0;
      hwm_q         <= '0;
    end else begin
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      hwm_q         <= hwm_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.almost_full = almost_full_q;
  assign bus.hwm         = hwm_q;

endmodule
